// File: rtl/ws2812_frame_ctrl_if.sv
// rtl/ws2812_frame_ctrl_if.sv - host, pixel RAM and RZ encoder signals of the WS2812 frame controller
interface ws2812_frame_ctrl_if;
    logic        start;
    logic        pix_rd;
    logic [7:0]  pix_addr;
    logic [23:0] pix_data;
    logic [23:0] RGB;
    logic        done_sig;
    logic        symbol;
    logic        line_en;
    logic        busy;
    logic        frame_done;

    // Controller side
    modport slave (
        input  start, pix_data, symbol,
        output pix_rd, pix_addr, RGB, done_sig, line_en, busy, frame_done
    );

    // Host / RAM / encoder side
    modport master (
        output start, pix_data, symbol,
        input  pix_rd, pix_addr, RGB, done_sig, line_en, busy, frame_done
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 frame sequencer: pixel fetch, gapless encoder feed, latch gap
module ws2812_frame_ctrl #(
    parameter int LED_NUM      = 8,
    parameter int LATCH_CYCLES = 15000
) (
    input  logic               clk,
    input  logic               rst_n,
    ws2812_frame_ctrl_if.slave bus
);
    localparam int            LW         = (LATCH_CYCLES > 65536) ? $clog2(LATCH_CYCLES) : 16;
    localparam logic [7:0]    LAST_IDX   = 8'(LED_NUM - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, PRIME, SEND, LATCH} state_t;
    state_t state, state_nxt;

    logic [7:0]    index;
    logic [4:0]    bit_cnt;
    logic [LW-1:0] latch_cnt;
    logic [23:0]   hold;
    // A prefetch read was strobed last cycle, so pix_data carries the next pixel now
    logic          pre_rd_q;
    logic          last_bit;
    logic          latch_end;

    assign last_bit       = (state == SEND) && bus.symbol && (bit_cnt == 5'd23);
    assign latch_end      = (state == LATCH) && (latch_cnt == LATCH_LAST);
    assign bus.frame_done = latch_end;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = PRIME;
            PRIME:   state_nxt = SEND;
            SEND:    if (last_bit && (index == LAST_IDX)) state_nxt = LATCH;
            LATCH:   if (latch_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: read strobes, encoder load, bit/pixel/latch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_rd   <= 1'b0;
            bus.pix_addr <= 8'd0;
            bus.RGB      <= 24'd0;
            bus.done_sig <= 1'b0;
            bus.line_en  <= 1'b0;
            bus.busy     <= 1'b0;
            index        <= 8'd0;
            bit_cnt      <= 5'd0;
            latch_cnt    <= '0;
            hold         <= 24'd0;
            pre_rd_q     <= 1'b0;
        end else begin
            bus.pix_rd   <= 1'b0;
            bus.done_sig <= 1'b0;
            pre_rd_q     <= bus.pix_rd && (state == SEND);
            if (pre_rd_q) begin
                hold <= bus.pix_data;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy     <= 1'b1;
                        index        <= 8'd0;
                        bus.pix_rd   <= 1'b1;
                        bus.pix_addr <= 8'd0;
                    end
                end
                PRIME: begin
                    bus.RGB      <= bus.pix_data;
                    bus.done_sig <= 1'b1;
                    bus.line_en  <= 1'b1;
                    bit_cnt      <= 5'd0;
                end
                SEND: begin
                    if (bus.symbol) begin
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= 5'd0;
                            if (index == LAST_IDX) begin
                                bus.line_en <= 1'b0;
                                latch_cnt   <= '0;
                            end else begin
                                // Next pixel goes out back-to-back with no gap bit
                                bus.RGB      <= hold;
                                bus.done_sig <= 1'b1;
                                index        <= index + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if ((bit_cnt == 5'd22) && (index != LAST_IDX)) begin
                                bus.pix_rd   <= 1'b1;
                                bus.pix_addr <= index + 8'd1;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        latch_cnt <= '0;
                        bus.busy  <= 1'b0;
                    end else begin
                        latch_cnt <= latch_cnt + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - scoreboard bench for ws2812_frame_ctrl with RAM and encoder models
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;
    localparam int LATCH = 200;
    localparam int GAP   = 24 * 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    ws2812_frame_ctrl_if bus3();
    ws2812_frame_ctrl_if bus1();

    ws2812_frame_ctrl #(.LED_NUM(3), .LATCH_CYCLES(LATCH)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    ws2812_frame_ctrl #(.LED_NUM(1), .LATCH_CYCLES(LATCH)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic [23:0] ram3 [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
    logic [23:0] ram1     = 24'h123456;

    logic sym3_m = 1'b0;
    logic sym1_m = 1'b0;
    logic inj    = 1'b0;
    assign bus3.symbol = sym3_m | inj;
    assign bus1.symbol = sym1_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_addr3 [$];
    logic [23:0] exp_rgb3  [$];
    logic [7:0]  exp_addr1 [$];
    logic [23:0] exp_rgb1  [$];

    int cyc = 0;
    int sym3 = 0, rd3 = 0, done3 = 0, fd3 = 0, last_done3 = -1;
    int sym1 = 0, rd1 = 0, done1 = 0, fd1 = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pixel RAM (data one cycle after pix_rd, junk otherwise) and RZ encoder model, LED_NUM=3
    initial begin : model3
        int cnt, bits;
        bit act, rdq;
        logic [7:0] aq;
        cnt = 0; bits = 0; act = 0; rdq = 0; aq = 0;
        bus3.pix_data = 24'h5A5A5A;
        forever begin
            @(posedge clk);
            #1;
            bus3.pix_data = (rdq && aq < 8'd3) ? ram3[aq[1:0]] : 24'h5A5A5A;
            rdq = bus3.pix_rd;
            aq  = bus3.pix_addr;
            if (!rst_n) begin
                act = 0; cnt = 0; bits = 0; rdq = 0;
            end else if (bus3.done_sig) begin
                act = 1; cnt = 0; bits = 0;
            end else if (act) begin
                cnt = (cnt == 59) ? 0 : cnt + 1;
            end
            sym3_m = act && (cnt == 59);
            if (sym3_m) begin
                bits++;
                if (bits == 24) act = 0;
            end
        end
    end

    // Same models for the LED_NUM=1 instance
    initial begin : model1
        int cnt, bits;
        bit act, rdq;
        logic [7:0] aq;
        cnt = 0; bits = 0; act = 0; rdq = 0; aq = 0;
        bus1.pix_data = 24'hA5A5A5;
        forever begin
            @(posedge clk);
            #1;
            bus1.pix_data = (rdq && aq == 8'd0) ? ram1 : 24'hA5A5A5;
            rdq = bus1.pix_rd;
            aq  = bus1.pix_addr;
            if (!rst_n) begin
                act = 0; cnt = 0; bits = 0; rdq = 0;
            end else if (bus1.done_sig) begin
                act = 1; cnt = 0; bits = 0;
            end else if (act) begin
                cnt = (cnt == 59) ? 0 : cnt + 1;
            end
            sym1_m = act && (cnt == 59);
            if (sym1_m) begin
                bits++;
                if (bits == 24) act = 0;
            end
        end
    end

    // Scoreboard pop side, LED_NUM=3
    initial begin : mon3
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                last_done3 = -1;
            end else begin
                if (bus3.symbol) sym3++;
                if (bus3.pix_rd) begin
                    rd3++;
                    if (exp_addr3.size() > 0) e = 32'(exp_addr3.pop_front());
                    else e = 32'hFFFF_FFFF;
                    check("rd3_addr", 32'(bus3.pix_addr), e);
                end
                if (bus3.done_sig) begin
                    done3++;
                    if (exp_rgb3.size() > 0) e = 32'(exp_rgb3.pop_front());
                    else e = 32'hFFFF_FFFF;
                    check("done3_rgb", 32'(bus3.RGB), e);
                    if (last_done3 >= 0) check("done3_gap", 32'(cyc - last_done3), 32'(GAP));
                    last_done3 = cyc;
                end
                if (bus3.frame_done) begin
                    fd3++;
                    last_done3 = -1;
                end
            end
        end
    end

    // Scoreboard pop side, LED_NUM=1
    initial begin : mon1
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (bus1.symbol) sym1++;
                if (bus1.pix_rd) begin
                    rd1++;
                    if (exp_addr1.size() > 0) e = 32'(exp_addr1.pop_front());
                    else e = 32'hFFFF_FFFF;
                    check("rd1_addr", 32'(bus1.pix_addr), e);
                end
                if (bus1.done_sig) begin
                    done1++;
                    if (exp_rgb1.size() > 0) e = 32'(exp_rgb1.pop_front());
                    else e = 32'hFFFF_FFFF;
                    check("done1_rgb", 32'(bus1.RGB), e);
                end
                if (bus1.frame_done) fd1++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic start3();
        for (int i = 0; i < 3; i++) begin
            exp_addr3.push_back(8'(i));
            exp_rgb3.push_back(ram3[i]);
        end
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
    endtask

    task automatic wait_sym3(input int target);
        int n;
        n = 0;
        while (sym3 < target && n < 8000) begin
            tick();
            n++;
        end
        if (sym3 < target) check("sym3_timeout", 32'(sym3), 32'(target));
    endtask

    task automatic wait_fd3();
        int n;
        n = 0;
        while (!bus3.frame_done && n < 8000) begin
            tick();
            n++;
        end
        if (!bus3.frame_done) check("fd3_timeout", 32'(bus3.frame_done), 32'd1);
    endtask

    task automatic check_quiet3(input string tag);
        check({tag, "_rgb"}, 32'(bus3.RGB), 32'd0);
        check({tag, "_ctl"}, 32'({bus3.done_sig, bus3.pix_rd, bus3.pix_addr,
                                  bus3.line_en, bus3.busy, bus3.frame_done}), 32'd0);
    endtask

    initial begin : main
        int base, n, rd_before, fd_before;
        bus3.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b0;
        repeat (4) tick();
        check_quiet3("reset3");
        check("reset1_ctl", 32'({bus1.pix_rd, bus1.done_sig, bus1.line_en, bus1.busy,
                                 bus1.frame_done}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Symbol pulses while idle must be ignored
        for (int i = 0; i < 4; i++) begin
            inj = 1'b1;
            tick();
            inj = 1'b0;
            tick();
        end
        repeat (3) tick();
        check("idle_sym_rd", 32'(rd3), 32'd0);
        check("idle_sym_done", 32'(done3), 32'd0);
        check("idle_sym_busy", 32'({bus3.busy, bus3.line_en}), 32'd0);

        // Frame 1 with start pulses during SEND, during LATCH and with frame_done
        base = sym3;
        start3();
        check("busy_after_start", 32'(bus3.busy), 32'd1);
        wait_sym3(base + 30);
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        wait_sym3(base + 72);
        check("line_en_at_s72", 32'(bus3.line_en), 32'd1);
        tick();
        check("line_en_after_s72", 32'(bus3.line_en), 32'd0);
        check("busy_in_latch", 32'(bus3.busy), 32'd1);
        n = 1;
        while (!bus3.frame_done && n < LATCH + 20) begin
            bus3.start = (n == 50);
            tick();
            n++;
        end
        bus3.start = 1'b0;
        check("latch_len", 32'(n), 32'(LATCH));
        check("busy_with_fd", 32'(bus3.busy), 32'd1);
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        check("busy_after_fd", 32'(bus3.busy), 32'd0);
        check("fd_one_cycle", 32'(bus3.frame_done), 32'd0);
        repeat (10) tick();
        check("ignored_starts_rd", 32'(rd3), 32'd3);
        check("frame1_done_cnt", 32'(done3), 32'd3);
        check("frame1_fd_cnt", 32'(fd3), 32'd1);
        check("still_idle_busy", 32'(bus3.busy), 32'd0);

        // Frame 2 from IDLE restarts at address 0
        start3();
        wait_fd3();
        tick();
        check("frame2_rd", 32'(rd3), 32'd6);
        check("frame2_done", 32'(done3), 32'd6);
        check("frame2_fd", 32'(fd3), 32'd2);

        // Frame 3 aborted by reset after the 30th symbol
        base = sym3;
        start3();
        wait_sym3(base + 30);
        rd_before = rd3;
        fd_before = fd3;
        rst_n = 1'b0;
        #1;
        check_quiet3("abort_now");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet3("abort_hold");
        end
        exp_addr3.delete();
        exp_rgb3.delete();
        rst_n = 1'b1;
        repeat (300) tick();
        check("abort_no_fd", 32'(fd3), 32'(fd_before));
        check("abort_no_rd", 32'(rd3), 32'(rd_before));
        check("abort_idle", 32'({bus3.busy, bus3.line_en}), 32'd0);
        start3();
        wait_fd3();
        tick();
        check("post_reset_rd", 32'(rd3), 32'(rd_before + 3));
        check("post_reset_fd", 32'(fd3), 32'(fd_before + 1));

        // Single-LED chain: one read, one load, then straight to the latch gap
        base = sym1;
        exp_addr1.push_back(8'd0);
        exp_rgb1.push_back(ram1);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.frame_done && n < 4000) begin
            tick();
            n++;
        end
        check("led1_fd_seen", 32'(bus1.frame_done), 32'd1);
        check("led1_syms", 32'(sym1 - base), 32'd24);
        check("led1_line_en", 32'(bus1.line_en), 32'd0);
        tick();
        check("led1_rd", 32'(rd1), 32'd1);
        check("led1_done", 32'(done1), 32'd1);
        check("led1_fd", 32'(fd1), 32'd1);
        check("led1_busy", 32'(bus1.busy), 32'd0);

        check("q3_drained", 32'(exp_addr3.size() + exp_rgb3.size()), 32'd0);
        check("q1_drained", 32'(exp_addr1.size() + exp_rgb1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ws2812_frame_ctrl.md
WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 SHALL have parameter LED_NUM, default 8, number of LEDs in the chain (1..256).
REQ-002 SHALL have parameter LATCH_CYCLES, default 15000, length of the latch (reset) gap in clk cycles (300 us at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to send one frame.
REQ-006 SHALL have port pix_rd, output, 1, one-cycle read strobe to the pixel RAM.
REQ-007 SHALL have port pix_addr, output, 8, pixel RAM address; valid while pix_rd=1.
REQ-008 SHALL have port pix_data, input, 24, GRB word from the pixel RAM, valid exactly one cycle after pix_rd.
REQ-009 SHALL have port RGB, output, 24, GRB word to the RZ encoder.
REQ-010 SHALL have port done_sig, output, 1, one-cycle load strobe to the encoder; RGB is valid in the same cycle.
REQ-011 SHALL have port symbol, input, 1, per-bit end strobe from the encoder, one cycle wide, once every 60 clk.
REQ-012 SHALL have port line_en, output, 1, high while encoder output may drive the LED line; low forces the line low.
REQ-013 SHALL have port busy, output, 1, high from the accepted start to the end of the latch gap.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse when the latch gap completes.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, PRIME, SEND, LATCH.
REQ-016 IDLE: start=1 -> FETCH, busy=1, pixel index=0; start in any other state SHALL be ignored.
REQ-017 FETCH SHALL assert pix_rd for one cycle with pix_addr=index, then go to PRIME.
REQ-018 PRIME SHALL, in the cycle pix_data is valid, load RGB<=pix_data and pulse done_sig, set line_en=1, clear bit count, and go to SEND.
REQ-019 SEND SHALL count symbol pulses, 5-bit, 0..23; symbol pulses outside SEND SHALL be ignored.
REQ-020 Prefetch: on the 23rd symbol pulse of a pixel (count 22->23) with index<LED_NUM-1, SHALL pulse pix_rd with pix_addr=index+1 and capture pix_data into a holding register the next cycle.
REQ-021 On the 24th symbol pulse with index<LED_NUM-1, in the same cycle, SHALL drive RGB<=holding register and done_sig=1, increment index, and clear count; no gap bits SHALL be inserted.
REQ-022 On the 24th symbol pulse with index=LED_NUM-1 -> LATCH: line_en<=0, latch counter cleared, no done_sig.
REQ-023 LATCH SHALL count LATCH_CYCLES clk cycles; at count LATCH_CYCLES-1 -> IDLE, with frame_done=1 for that cycle and busy=0 from the next cycle.
REQ-024 LED_NUM=1: no prefetch read; the 24th symbol goes directly to LATCH.
REQ-025 pix_rd SHALL be issued exactly LED_NUM times per frame, at addresses 0..LED_NUM-1 in order.
REQ-026 RGB SHALL hold its value between done_sig pulses.
REQ-027 The latch counter SHALL be wide enough for LATCH_CYCLES (16 bits minimum), with no wrap.
REQ-028 start arriving in the same cycle as frame_done SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, RGB=0, done_sig=0, pix_rd=0, pix_addr=0, line_en=0, busy=0, frame_done=0, all counters and holding register 0.
REQ-030 Reset mid-frame SHALL abort the frame with no frame_done; the next start after release SHALL restart at address 0.

Verification
REQ-031 LED_NUM=3, RAM {0xFF0000,0x00FF00,0x0000FF}, symbol model every 60 clk, start -> pix_rd at addr 0,1,2; done_sig three times with RGB equal to those words in order; done_sig spacing 24*60=1440 clk.
REQ-032 After the 72nd symbol -> line_en=0 next cycle; frame_done exactly LATCH_CYCLES clk later; busy falls the cycle after frame_done.
REQ-033 LED_NUM=1, start -> one pix_rd, one done_sig, LATCH after 24 symbols, no second read.
REQ-034 start pulsed during SEND and during LATCH -> no effect, read count unchanged; start in IDLE after frame_done -> new frame at addr 0.
REQ-035 rst_n low after the 30th symbol, held 3 cycles -> all outputs 0 within the reset; later start -> pix_addr=0, normal frame.
REQ-036 symbol pulses injected in IDLE -> no done_sig, no pix_rd, state unchanged.
